// File: rtl/popcount_seq_ctrl.sv
// Sequential population counter: one 7-bit popcount per cycle over a wide word,
// with a valid/ready handshake on the input and on the output.
module popcount_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
);

  localparam int NCH = (WIDTH + 6) / 7;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW  = NCH * 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    chunk;
  logic [2:0]    chunk_pc;
  logic          last_chunk;

  always_comb begin
    chunk    = data_q[idx_q*7 +: 7];
    chunk_pc = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      chunk_pc = chunk_pc + {2'b00, chunk[i]};
    end
  end

  assign last_chunk = (idx_q == IW'(NCH - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // padding bits above WIDTH stay zero so the last chunk counts cleanly
          data_d             = '0;
          data_d[WIDTH-1:0]  = in_data;
          acc_d              = '0;
          idx_d              = '0;
          state_d            = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = acc_q + CW'(chunk_pc);
          if (last_chunk) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          acc_d   = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Bench for popcount_seq_ctrl: WIDTH=32 and WIDTH=7 instances checked against
// a cycle-count/result model every cycle, plus hand-computed directed checks.
module tb_popcount_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv_a = 1'b0, ab_a = 1'b0, or_a = 1'b1;
  logic        ir_a, ov_a, busy_a;
  logic [31:0] id_a = '0;
  logic [5:0]  oc_a;

  logic        iv_b = 1'b0, ab_b = 1'b0, or_b = 1'b1;
  logic        ir_b, ov_b, busy_b;
  logic [6:0]  id_b = '0;
  logic [2:0]  oc_b;

  int vectors = 0;
  int miscompares = 0;

  popcount_seq_ctrl #(.WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .abort(ab_a), .out_valid(ov_a), .out_ready(or_a), .out_count(oc_a), .busy(busy_a)
  );

  popcount_seq_ctrl #(.WIDTH(7)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .abort(ab_b), .out_valid(ov_b), .out_ready(or_b), .out_count(oc_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word occupies the block for nch cycles of counting, then the
  // result waits until taken or aborted.
  int m_left[2];
  int m_res[2];
  bit m_have[2];

  function automatic void step(input int k, input int nch, input bit iv,
                               input int ones, input bit ab, input bit ordy);
    if (m_left[k] > 0) begin
      if (ab) m_left[k] = 0;
      else begin
        m_left[k]--;
        if (m_left[k] == 0) m_have[k] = 1'b1;
      end
    end else if (m_have[k]) begin
      if (ab || ordy) m_have[k] = 1'b0;
    end else if (iv) begin
      m_left[k] = nch;
      m_res[k]  = ones;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0;
        m_have[k] = 1'b0;
        m_res[k]  = 0;
      end
    end else begin
      step(0, 5, iv_a, $countones(id_a), ab_a, or_a);
      step(1, 1, iv_b, $countones(id_b), ab_b, or_b);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_in_ready",  int'(ir_a),   int'(!(m_left[0] > 0 || m_have[0])));
      chk("a_busy",      int'(busy_a), int'(m_left[0] > 0 || m_have[0]));
      chk("a_out_valid", int'(ov_a),   int'(m_have[0]));
      chk("a_out_count", int'(oc_a),   m_have[0] ? m_res[0] : 0);
      chk("b_in_ready",  int'(ir_b),   int'(!(m_left[1] > 0 || m_have[1])));
      chk("b_busy",      int'(busy_b), int'(m_left[1] > 0 || m_have[1]));
      chk("b_out_valid", int'(ov_b),   int'(m_have[1]));
      chk("b_out_count", int'(oc_b),   m_have[1] ? m_res[1] : 0);
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_in_ready"},  int'(ir_a),   1);
    chk({tag, "_busy"},      int'(busy_a), 0);
    chk({tag, "_out_valid"}, int'(ov_a),   0);
    chk({tag, "_out_count"}, int'(oc_a),   0);
  endtask

  // Send one word on instance A, check latency and count, hold off the
  // consumer for `hold` cycles, then check the handshake returns to idle.
  task automatic run_a(input logic [31:0] w, input int exp_cnt, input int hold);
    int n;
    or_a = (hold == 0);
    @(negedge clk);
    iv_a = 1'b1;
    id_a = w;
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    ab_a = 1'b0;
    id_a = $urandom;
    n = 0;
    while (!ov_a && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_latency", n, 5);
    chk("a_count", int'(oc_a), exp_cnt);
    if (hold > 0) begin
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        chk("a_hold_valid", int'(ov_a), 1);
        chk("a_hold_count", int'(oc_a), exp_cnt);
        chk("a_hold_in_ready", int'(ir_a), 0);
      end
      or_a = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("a_post_valid", int'(ov_a), 0);
    chk("a_post_in_ready", int'(ir_a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #12;
    chk_reset_a("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    run_a(32'hFFFF_FFFF, 32, 0);
    run_a(32'h0000_0000, 0, 0);
    ab_a = 1'b1;  // abort is ignored while idle; the word must still be accepted
    run_a(32'h8000_0001, 2, 0);
    run_a(32'h0000_007F, 7, 0);
    run_a(32'h0F0F_0F0F, 16, 10);

    // abort in the third counting cycle
    @(negedge clk);
    iv_a = 1'b1;
    id_a = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 iv_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 ab_a = 1'b1;
    @(posedge clk);
    #1 ab_a = 1'b0;
    chk("abort_in_ready", int'(ir_a), 1);
    chk("abort_out_valid", int'(ov_a), 0);
    repeat (6) @(posedge clk);
    #1 chk("abort_no_result", int'(ov_a), 0);
    run_a(32'h0000_0003, 2, 0);

    // asynchronous reset while counting
    @(negedge clk);
    iv_a = 1'b1;
    id_a = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 iv_a = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_a("rst_run");
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset while a result is waiting
    or_a = 1'b0;
    @(negedge clk);
    iv_a = 1'b1;
    id_a = 32'h1234_5678;
    @(posedge clk);
    #1 iv_a = 1'b0;
    n = 0;
    while (!ov_a && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_done_reached", int'(ov_a), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_a("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    or_a = 1'b1;
    run_a(32'hAAAA_AAAA, 16, 0);

    // narrow instance: single chunk, single counting cycle
    @(negedge clk);
    iv_b = 1'b1;
    id_b = 7'b1011011;
    @(posedge clk);
    #1;
    iv_b = 1'b0;
    id_b = 7'b0000000;
    n = 0;
    while (!ov_b && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_latency", n, 1);
    chk("b_count", int'(oc_b), 5);
    @(posedge clk);
    #1 chk("b_post_in_ready", int'(ir_b), 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
